key_debounce: RTL and testbench
===============================

// Module: key_debounce
// PURPOSE
//   Conditions the raw push-button inputs before they reach game_top.
//   Per key: 2-flop synchroniser, counter-based debounce FSM, and polarity
//   normalisation to active-high. Outputs are a clean held level (paddle
//   motion) plus one-cycle press/release strobes (serve/start).
//   Sits between the board pins and game_top.keys_i.
// PARAMETERS
//   CLK_MHZ     50     clock frequency in MHz
//   DEBOUNCE_US 10000  stable time required, in us; N = CLK_MHZ*DEBOUNCE_US cycles (N >= 1)
//   N_KEYS      2      number of independent keys
//   ACTIVE_LOW  1      1: raw key reads 0 when pressed; 0: raw key reads 1 when pressed
// PORTS
//   clk_i      in   1       system clock, all logic on rising edge
//   rst_i      in   1       synchronous reset, active-high
//   keys_i     in   N_KEYS  raw asynchronous button pins
//   keys_o     out  N_KEYS  debounced level, 1 = pressed
//   press_o    out  N_KEYS  1-cycle strobe on debounced press
//   release_o  out  N_KEYS  1-cycle strobe on debounced release
// BEHAVIOUR
//   - One clock (clk_i); reset is synchronous and active-high (rst_i).
//   - Reset: keys_o = press_o = release_o = 0; every FSM in RELEASED;
//     counters = 0; synchroniser flops = released level (1 if ACTIVE_LOW).
//   - Sync: s[k] = raw keys_i[k] delayed 2 cycles, then inverted if ACTIVE_LOW
//     (s = 1 means pressed).
//   - Counter width $clog2(N+1); one counter per key; never wraps.
//   - FSM per key, states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT:
//       RELEASED:     s=1 -> PRESS_WAIT, cnt <= 0; else stay.
//       PRESS_WAIT:   s=0 -> RELEASED, cnt <= 0 (glitch rejected, no strobe);
//                     s=1 & cnt==N-1 -> PRESSED; s=1 otherwise cnt <= cnt+1.
//       PRESSED:      s=0 -> RELEASE_WAIT, cnt <= 0; else stay.
//       RELEASE_WAIT: s=1 -> PRESSED, cnt <= 0 (no strobe);
//                     s=0 & cnt==N-1 -> RELEASED; s=0 otherwise cnt <= cnt+1.
//   - Outputs registered: keys_o[k] = 1 in PRESSED and RELEASE_WAIT.
//     press_o[k] = 1 for exactly the cycle after the PRESS_WAIT->PRESSED
//     transition, i.e. the first cycle keys_o[k] is 1. release_o[k] likewise
//     on the first cycle keys_o[k] is 0 after RELEASE_WAIT->RELEASED.
//   - Latency: raw edge sampled at clock edge r -> keys_o changes at edge
//     r+N+3 (2 sync + 1 FSM entry + N wait cycles), provided the input is
//     stable for all N+1 FSM samples.
//   - Any bounce during a WAIT state restarts from the stable state; the
//     full N+1 samples are required again from the next change.
//   - press_o and release_o are never both 1 for one key in one cycle.
//     Keys are fully independent; simultaneous activity on different keys
//     is handled in parallel.
//   - rst_i mid-debounce or while pressed: the next cycle is the reset state,
//     and no strobe is emitted. A key held through reset release produces
//     a normal press (strobe included) N+3 cycles after rst_i deasserts.
// TESTING  (CLK_MHZ=1, DEBOUNCE_US=8 -> N=8, N_KEYS=2, ACTIVE_LOW=1)
//   1. Reset, keys_i=2'b11 held 50 cycles -> all outputs 0 throughout.
//   2. keys_i[0] 1->0 at edge r, held -> keys_o[0]=1 from edge r+11;
//      press_o[0]=1 only at r+11; key 1 outputs stay 0.
//   3. Pressed key 0, then 4-cycle pulses 1,0,1,0 on keys_i[0] -> no
//      change on keys_o or release_o; a later stable 1 gives release_o[0]
//      for one cycle, 11 cycles after the final edge.
//   4. Both keys pressed at the same edge -> press_o=2'b11 in the same cycle;
//      keys_o=2'b11.
//   5. rst_i=1 during PRESS_WAIT (cycle 6 after edge) while keys_i[0]=0 held ->
//      outputs stay 0; press_o[0] occurs 11 cycles after rst_i falls.
//   6. 7-cycle low glitch on keys_i[1] (< N+1 samples) -> no press_o,
//      keys_o[1] stays 0.

Source files
------------

// File: rtl/key_debounce.sv
// key_debounce: conditions raw push-button pins for game_top.
// Each key passes through a two-flop synchroniser, is normalised to
// active-high, and is debounced by a counter-driven four-state FSM. The block
// presents a clean held level plus single-cycle press and release strobes.
module key_debounce #(
    parameter int CLK_MHZ     = 50,
    parameter int DEBOUNCE_US = 10000,
    parameter int N_KEYS      = 2,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_KEYS-1:0] keys_i,
    output logic [N_KEYS-1:0] keys_o,
    output logic [N_KEYS-1:0] press_o,
    output logic [N_KEYS-1:0] release_o
);

    // Number of consecutive FSM samples (after the entry sample) required
    // before a new level is accepted.
    localparam int N     = CLK_MHZ * DEBOUNCE_US;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Raw pin level that means "not pressed"; the synchroniser resets to it
    // so that leaving reset never looks like a press edge.
    localparam logic [N_KEYS-1:0] RAW_IDLE = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}}
                                                               : {N_KEYS{1'b0}};

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Synchroniser stages
    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync1_d;
    logic [N_KEYS-1:0] sync2_q;
    logic [N_KEYS-1:0] sync2_d;

    // Synchronised, polarity-normalised key level (1 = pressed)
    logic [N_KEYS-1:0] pressed_s;

    // Per-key debounce FSM and stability counter
    state_t           state_q [N_KEYS];
    state_t           state_d [N_KEYS];
    logic [CNT_W-1:0] cnt_q   [N_KEYS];
    logic [CNT_W-1:0] cnt_d   [N_KEYS];

    // Registered outputs
    logic [N_KEYS-1:0] keys_q;
    logic [N_KEYS-1:0] keys_d;
    logic [N_KEYS-1:0] press_q;
    logic [N_KEYS-1:0] press_d;
    logic [N_KEYS-1:0] release_q;
    logic [N_KEYS-1:0] release_d;

    // Synchroniser next values and active-high normalisation of the last stage
    always_comb begin
        sync1_d   = keys_i;
        sync2_d   = sync1_q;
        pressed_s = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    end

    // Synchroniser flops, parked at the released pin level during reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= RAW_IDLE;
            sync2_q <= RAW_IDLE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // FSM state register: state and stability counter for every key
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < N_KEYS; k++) begin
            if (rst_i) begin
                state_q[k] <= RELEASED;
                cnt_q[k]   <= CNT_ZERO;
            end else begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    // FSM next state: any disagreement during a wait state falls back to the
    // stable state, so a bounce always restarts the full qualification window
    always_comb begin
        for (int k = 0; k < N_KEYS; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            case (state_q[k])
                RELEASED: begin
                    if (pressed_s[k]) begin
                        state_d[k] = PRESS_WAIT;
                        cnt_d[k]   = CNT_ZERO;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed_s[k]) begin
                        state_d[k] = RELEASED;
                        cnt_d[k]   = CNT_ZERO;
                    end else if (cnt_q[k] == CNT_LAST) begin
                        state_d[k] = PRESSED;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!pressed_s[k]) begin
                        state_d[k] = RELEASE_WAIT;
                        cnt_d[k]   = CNT_ZERO;
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed_s[k]) begin
                        state_d[k] = PRESSED;
                        cnt_d[k]   = CNT_ZERO;
                    end else if (cnt_q[k] == CNT_LAST) begin
                        state_d[k] = RELEASED;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[k] = RELEASED;
                    cnt_d[k]   = CNT_ZERO;
                end
            endcase
        end
    end

    // FSM outputs: held level from the current state, strobes on its edges
    always_comb begin
        keys_d = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            keys_d[k] = (state_q[k] == PRESSED) || (state_q[k] == RELEASE_WAIT);
        end
        press_d   = keys_d & ~keys_q;
        release_d = ~keys_d & keys_q;
    end

    // Output registers; reset clears them so no strobe leaks out of reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            keys_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            keys_q    <= keys_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign keys_o    = keys_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scoreboarded bench for key_debounce with N=8, two
// active-low keys. A run-length reference model predicts every output cycle;
// directed scenarios measure latencies and glitch rejection.
module tb_key_debounce;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [1:0] keys_i = 2'b11;
    logic [1:0] keys_o;
    logic [1:0] press_o;
    logic [1:0] release_o;

    int total = 0;
    int bad = 0;

    // Expected {keys, press, release} per clock edge
    logic [5:0] sbQueue [$];

    // Reference model state: raw pin delay line, accepted level, and the
    // length of the current run of samples disagreeing with that level
    logic [1:0] mSync1 = 2'b11;
    logic [1:0] mSync2 = 2'b11;
    logic [1:0] mLevel = 2'b00;
    logic [1:0] mOut = 2'b00;
    int         mRun [2] = '{0, 0};

    key_debounce #(
        .CLK_MHZ    (1),
        .DEBOUNCE_US(8),
        .N_KEYS     (2),
        .ACTIVE_LOW (1)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .keys_i   (keys_i),
        .keys_o   (keys_o),
        .press_o  (press_o),
        .release_o(release_o)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Reference model: a level flips once N+1 consecutive synchronised
    // samples disagree with it; the outputs show that level one edge later
    always @(posedge clk) begin
        if (rst_i) begin
            sbQueue.push_back(6'b0);
            mSync1 <= 2'b11;
            mSync2 <= 2'b11;
            mLevel <= 2'b00;
            mOut   <= 2'b00;
            for (int k = 0; k < 2; k++) mRun[k] <= 0;
        end else begin
            sbQueue.push_back({mLevel, mLevel & ~mOut, ~mLevel & mOut});
            mOut   <= mLevel;
            mSync1 <= keys_i;
            mSync2 <= mSync1;
            for (int k = 0; k < 2; k++) begin
                if ((!mSync2[k]) == mLevel[k]) begin
                    mRun[k] <= 0;
                end else if (mRun[k] + 1 == N + 1) begin
                    mLevel[k] <= !mSync2[k];
                    mRun[k]   <= 0;
                end else begin
                    mRun[k] <= mRun[k] + 1;
                end
            end
        end
    end

    // Monitor: pops the prediction for the last edge and compares mid-cycle
    always @(negedge clk) begin
        if (sbQueue.size() > 0) begin
            logic [5:0] expVal;
            expVal = sbQueue.pop_front();
            total++;
            if ({keys_o, press_o, release_o} !== expVal) begin
                bad++;
                $display("[TB] FAIL scoreboard t=%0t got keys=%b press=%b rel=%b want keys=%b press=%b rel=%b",
                         $time, keys_o, press_o, release_o, expVal[5:4], expVal[3:2], expVal[1:0]);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s got %0d want %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] keysVal, input logic rstVal);
        @(negedge clk);
        keys_i = keysVal;
        rst_i  = rstVal;
    endtask

    // Cycles from the edge sampling the new stimulus to the first strobe
    task automatic measureStrobe(input int key, input bit isPress, output int lat);
        lat = -1;
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if ((isPress ? press_o[key] : release_o[key]) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int cnt;
        int hold [2];
        logic [1:0] val;

        // Reset, then idle with both keys released
        repeat (3) @(negedge clk);
        applyStimulus(2'b11, 1'b0);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if ({keys_o, press_o, release_o} != 6'b0) cnt++;
        end
        checkOutput("idle_outputs_active", cnt, 0);

        // Press key 0 and hold
        applyStimulus(2'b10, 1'b0);
        measureStrobe(0, 1'b1, lat);
        checkOutput("press0_latency", lat, 11);
        checkOutput("press0_level", int'(keys_o[0]), 1);
        checkOutput("key1_idle", int'({keys_o[1], press_o[1]}), 0);
        @(posedge clk);
        #1;
        checkOutput("press0_one_cycle", int'(press_o[0]), 0);

        // Short bounces while pressed, then a genuine release
        applyStimulus(2'b11, 1'b0);
        repeat (3) @(negedge clk);
        applyStimulus(2'b10, 1'b0);
        repeat (3) @(negedge clk);
        applyStimulus(2'b11, 1'b0);
        repeat (3) @(negedge clk);
        applyStimulus(2'b10, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("bounce_keeps_level", int'(keys_o[0]), 1);
        applyStimulus(2'b11, 1'b0);
        measureStrobe(0, 1'b0, lat);
        checkOutput("release0_latency", lat, 11);
        checkOutput("release0_level", int'(keys_o[0]), 0);
        repeat (5) @(negedge clk);

        // Both keys pressed together, then released together
        applyStimulus(2'b00, 1'b0);
        measureStrobe(0, 1'b1, lat);
        checkOutput("both_press_latency", lat, 11);
        checkOutput("both_press_strobe", int'(press_o), 3);
        checkOutput("both_keys_level", int'(keys_o), 3);
        applyStimulus(2'b11, 1'b0);
        measureStrobe(1, 1'b0, lat);
        checkOutput("both_release_latency", lat, 11);
        checkOutput("both_release_strobe", int'(release_o), 3);
        repeat (5) @(negedge clk);

        // Reset during PRESS_WAIT with key 0 held through it
        applyStimulus(2'b10, 1'b0);
        repeat (6) @(posedge clk);
        applyStimulus(2'b10, 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_clears_outputs", int'({keys_o, press_o, release_o}), 0);
        applyStimulus(2'b10, 1'b0);
        measureStrobe(0, 1'b1, lat);
        checkOutput("press_after_reset_latency", lat, 11);
        applyStimulus(2'b11, 1'b0);
        repeat (15) @(negedge clk);

        // Seven-cycle glitch on key 1 must be rejected
        applyStimulus(2'b01, 1'b0);
        repeat (6) @(negedge clk);
        applyStimulus(2'b11, 1'b0);
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (press_o[1] || keys_o[1]) cnt++;
        end
        checkOutput("glitch_rejected", cnt, 0);

        // Randomised bouncing on both keys with occasional resets
        val = 2'b11;
        hold[0] = 1;
        hold[1] = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                hold[k]--;
                if (hold[k] <= 0) begin
                    val[k] = ~val[k];
                    hold[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 25))
                                                          : int'($urandom_range(1, 14));
                end
            end
            applyStimulus(val, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end

        // Quiet down and confirm everything settles released
        applyStimulus(2'b11, 1'b0);
        repeat (30) @(negedge clk);
        checkOutput("final_released", int'(keys_o), 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
